// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader and its per-core banks.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CORE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_COMMIT
    } state_t;

    localparam logic [7:0]  SYNC_BYTE      = 8'h5A;
    localparam int unsigned DEF_PROG_DEPTH = 15;
    localparam int unsigned DEF_INSTR_W    = 16;

    // Program-counter / length type shared with core.
    typedef logic [3:0] pc_len_t;

endpackage

// File: rtl/prog_bank.sv
// Live instruction store, program length and run flag for one core.
module prog_bank
    import prog_loader_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = DEF_PROG_DEPTH,
    parameter int unsigned INSTR_W    = DEF_INSTR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          run_clr,
    input  pc_len_t                       len_in,
    input  logic [PROG_DEPTH*INSTR_W-1:0] data_in,
    output logic [PROG_DEPTH*INSTR_W-1:0] prog,
    output pc_len_t                       p_length,
    output logic                          run
);

    logic [PROG_DEPTH*INSTR_W-1:0] store_q, store_d;
    pc_len_t                       len_q, len_d;
    logic                          run_q, run_d;

    always_comb begin
        store_d = store_q;
        len_d   = len_q;
        run_d   = run_q;
        if (run_clr) begin
            run_d = 1'b0;
        end
        if (load) begin
            store_d = data_in;
            len_d   = len_in;
            run_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q <= '0;
            len_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            store_q <= store_d;
            len_q   <= len_d;
            run_q   <= run_d;
        end
    end

    assign prog     = store_q;
    assign p_length = len_q;
    assign run      = run_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream frame parser that loads per-core programs through a shadow store.
// Optional trailing XOR checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned NCORES     = 2,
    parameter int unsigned PROG_DEPTH = DEF_PROG_DEPTH,
    parameter int unsigned INSTR_W    = DEF_INSTR_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [7:0]                           in_data,
    output logic [NCORES*PROG_DEPTH*INSTR_W-1:0] prog,
    output logic [NCORES*4-1:0]                  pLength,
    output logic [NCORES-1:0]                    run,
    output logic                                 done,
    output logic                                 err
);

    localparam int unsigned IDX_W    = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int unsigned STORE_W  = PROG_DEPTH * INSTR_W;
    localparam logic [7:0]  NCORES_B = 8'(NCORES);
    localparam logic [7:0]  DEPTH_B  = 8'(PROG_DEPTH);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    pc_len_t            len_q, len_d;
    pc_len_t            k_q, k_d;
    logic [7:0]         hi_q, hi_d;
    logic [7:0]         csum_q, csum_d;
    logic [STORE_W-1:0] shadow_q, shadow_d;
    logic               err_q, err_d;

    logic               accept;
    logic               commit_now;
    logic               run_clr_now;
    pc_len_t            commit_len;
    logic [STORE_W-1:0] commit_data;
    logic [15:0]        word;

    assign in_ready = (state_q != ST_COMMIT);
    assign accept   = in_valid && in_ready;
    assign done     = (state_q == ST_COMMIT);
    assign err      = err_q;
    assign word     = {hi_q, in_data};

    // Banks load on the edge that enters COMMIT, so the store, length, run and
    // done all become visible together in the COMMIT cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        k_d         = k_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        shadow_d    = shadow_q;
        err_d       = 1'b0;
        commit_now  = 1'b0;
        run_clr_now = 1'b0;
        commit_len  = len_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && in_data == SYNC_BYTE) begin
                    csum_d  = '0;
                    state_d = ST_CORE;
                end
            end
            ST_CORE: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    if (in_data >= NCORES_B) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d       = IDX_W'(in_data);
                        run_clr_now = 1'b1;
                        state_d     = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    k_d    = '0;
                    if (in_data > DEPTH_B) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        len_d      = pc_len_t'(in_data);
                        commit_len = len_d;
                        if (in_data == 8'h00) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            commit_now = 1'b1;
                            state_d    = ST_COMMIT;
`endif
                        end else begin
                            state_d = ST_HI;
                        end
                    end
                end
            end
            ST_HI: begin
                if (accept) begin
                    csum_d  = csum_q ^ in_data;
                    hi_d    = in_data;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    for (int unsigned s = 0; s < PROG_DEPTH; s++) begin
                        if (k_q == pc_len_t'(s)) begin
                            shadow_d[s*INSTR_W +: INSTR_W] = INSTR_W'(word);
                        end
                    end
                    if (k_q == len_q - 4'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        commit_now = 1'b1;
                        state_d    = ST_COMMIT;
`endif
                    end else begin
                        k_d     = k_q + 4'd1;
                        state_d = ST_HI;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        commit_now = 1'b1;
                        state_d    = ST_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Slots at or beyond the new length are zeroed in the committed image.
    always_comb begin
        commit_data = '0;
        for (int unsigned s = 0; s < PROG_DEPTH; s++) begin
            if (pc_len_t'(s) < commit_len) begin
                commit_data[s*INSTR_W +: INSTR_W] = shadow_d[s*INSTR_W +: INSTR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            k_q      <= '0;
            hi_q     <= '0;
            csum_q   <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            k_q      <= k_d;
            hi_q     <= hi_d;
            csum_q   <= csum_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    for (genvar c = 0; c < NCORES; c++) begin : g_bank
        prog_bank #(
            .PROG_DEPTH (PROG_DEPTH),
            .INSTR_W    (INSTR_W)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .load     (commit_now && (idx_q == IDX_W'(c))),
            .run_clr  (run_clr_now && (idx_d == IDX_W'(c))),
            .len_in   (commit_len),
            .data_in  (commit_data),
            .prog     (prog[c*STORE_W +: STORE_W]),
            .p_length (pLength[c*4 +: 4]),
            .run      (run[c])
        );
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a frame-level expectation model checked every cycle.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int unsigned NC      = 2;
    localparam int unsigned PD      = 15;
    localparam int unsigned IW      = 16;
    localparam int unsigned TOTAL_W = NC * PD * IW;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic [TOTAL_W-1:0] prog;
    logic [NC*4-1:0]    pLength;
    logic [NC-1:0]      run;
    logic               done;
    logic               err;

    prog_loader #(
        .NCORES     (NC),
        .PROG_DEPTH (PD),
        .INSTR_W    (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .prog     (prog),
        .pLength  (pLength),
        .run      (run),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Expected outputs, updated at frame level by the stimulus tasks.
    logic [TOTAL_W-1:0] exp_prog;
    logic [NC*4-1:0]    exp_len;
    logic [NC-1:0]      exp_run;
    logic               exp_done;
    logic               exp_err;
    logic               exp_ready;
    logic [15:0]        fr_ins [16];

    int total = 0;
    int bad   = 0;
    int ready_lo = 0;

    always @(negedge clk) begin
        total++;
        if (prog !== exp_prog) begin
            bad++;
            $display("FAIL prog: got %h want %h", prog, exp_prog);
        end
        total++;
        if (pLength !== exp_len) begin
            bad++;
            $display("FAIL pLength: got %h want %h", pLength, exp_len);
        end
        total++;
        if (run !== exp_run) begin
            bad++;
            $display("FAIL run: got %b want %b", run, exp_run);
        end
        total++;
        if (done !== exp_done) begin
            bad++;
            $display("FAIL done: got %b want %b", done, exp_done);
        end
        total++;
        if (err !== exp_err) begin
            bad++;
            $display("FAIL err: got %b want %b", err, exp_err);
        end
        total++;
        if (in_ready !== exp_ready) begin
            bad++;
            $display("FAIL in_ready: got %b want %b", in_ready, exp_ready);
        end
        if (!in_ready) ready_lo++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic model_reset();
        exp_prog  = '0;
        exp_len   = '0;
        exp_run   = '0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic model_commit(input int core, input int len);
        for (int s = 0; s < PD; s++)
            exp_prog[(core*PD+s)*IW +: IW] = (s < len) ? fr_ins[s] : 16'h0000;
        exp_len[core*4 +: 4] = 4'(len);
        exp_run[core] = 1'b1;
        exp_done  = 1'b1;
        exp_ready = 1'b0;
    endtask

    // Advance one clock; pulse expectations last exactly one cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 20);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL handshake: byte %h not accepted after %0d cycles", b, n);
        end
    endtask

    task automatic send_frame(input int core, input int len, input bit bad_csum);
        logic [7:0] cs;
        cs = 8'(core) ^ 8'(len);
        send_byte(8'h5A);
        send_byte(8'(core));
        if (core >= NC) begin
            exp_err  = 1'b1;
            in_valid = 1'b0;
            return;
        end
        exp_run[core] = 1'b0;
        send_byte(8'(len));
        if (len > PD) begin
            exp_err  = 1'b1;
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < len; i++) begin
            send_byte(fr_ins[i][15:8]);
            send_byte(fr_ins[i][7:0]);
            cs = cs ^ fr_ins[i][15:8] ^ fr_ins[i][7:0];
        end
        if (CSUM_EN) begin
            send_byte(bad_csum ? (cs ^ 8'h01) : cs);
            if (bad_csum) begin
                exp_err  = 1'b1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        model_commit(core, len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo_before;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        model_reset();
        tick();
        tick();
        check("reset_prog_zero", 64'(|prog), 64'd0);
        check("reset_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        tick();

        // Basic frame to core 0, checksum 0x42.
        fr_ins[0] = 16'h1234;
        fr_ins[1] = 16'hABCD;
        send_frame(0, 2, 1'b0);
        check("t1_slot0", 64'(prog[15:0]), 64'h1234);
        check("t1_slot1", 64'(prog[31:16]), 64'hABCD);
        check("t1_slots_rest", 64'(|prog[PD*IW-1:32]), 64'd0);
        check("t1_plen0", 64'(pLength[3:0]), 64'd2);
        check("t1_run", 64'(run), 64'b01);
        check("t1_done", 64'(done), 64'd1);
        check("t1_core1", 64'(|prog[TOTAL_W-1:PD*IW]), 64'd0);
        tick();

`ifdef PROG_LOADER_CHECKSUM_EN
        fr_ins[0] = 16'h1111;
        fr_ins[1] = 16'h2222;
        send_frame(0, 2, 1'b1);
        check("t2_err", 64'(err), 64'd1);
        check("t2_slot0_kept", 64'(prog[15:0]), 64'h1234);
        check("t2_run0_low", 64'(run[0]), 64'd0);
        tick();
`endif

        // Out-of-range core, then a good frame to core 1.
        send_frame(2, 0, 1'b0);
        check("t3_err", 64'(err), 64'd1);
        tick();
        fr_ins[0] = 16'hBEEF;
        send_frame(1, 1, 1'b0);
        check("t3_core1_slot0", 64'(prog[PD*IW +: 16]), 64'hBEEF);
        check("t3_plen1", 64'(pLength[7:4]), 64'd1);
        tick();

        // Over-length frame, then a zero-length frame to core 1.
        send_frame(0, 16, 1'b0);
        check("t4_err", 64'(err), 64'd1);
        check("t4_run0_low", 64'(run[0]), 64'd0);
        tick();
        send_frame(1, 0, 1'b0);
        check("t4_plen1", 64'(pLength[7:4]), 64'd0);
        check("t4_run1", 64'(run[1]), 64'd1);
        check("t4_core1_cleared", 64'(prog[PD*IW +: 16]), 64'h0000);
        tick();

        // Reset after the first HI byte of a frame.
        send_byte(8'h5A);
        send_byte(8'h00);
        exp_run[0] = 1'b0;
        send_byte(8'h02);
        send_byte(8'h12);
        in_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        check("t5_rst_run", 64'(run), 64'd0);
        check("t5_rst_plen", 64'(pLength), 64'd0);
        rst = 1'b0;
        tick();
        fr_ins[0] = 16'h1234;
        fr_ins[1] = 16'hABCD;
        send_frame(0, 2, 1'b0);
        check("t5_slot1", 64'(prog[31:16]), 64'hABCD);
        tick();

        // Garbage, then back-to-back frames (second carries a SYNC value as data).
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5B);
        in_valid = 1'b0;
        tick();
        lo_before = ready_lo;
        fr_ins[0] = 16'h0001;
        fr_ins[1] = 16'h5A5A;
        fr_ins[2] = 16'hFFFF;
        send_frame(0, 3, 1'b0);
        fr_ins[0] = 16'hCAFE;
        fr_ins[1] = 16'h0F0F;
        send_frame(1, 2, 1'b0);
        tick();
        tick();
        check("t6_ready_low_cycles", 64'(ready_lo - lo_before), 64'd2);
        check("t6_core0_slot1", 64'(prog[31:16]), 64'h5A5A);
        check("t6_core0_slot2", 64'(prog[47:32]), 64'hFFFF);
        check("t6_core1_slot0", 64'(prog[PD*IW +: 16]), 64'hCAFE);
        check("t6_plen", 64'(pLength), 64'h23);
        check("t6_run", 64'(run), 64'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Streams TIS node programs from a byte-wide host interface into per-core instruction stores, and drives the `prog` and `pLength` inputs of each `core` instance, replacing the `$readmemh` image used in simulation. Frames are parsed by an FSM, buffered in a shadow store, validated, and committed atomically. Each core is held stopped while its program is being replaced.

## Interface
- `NCORES`, default 2: number of cores served.
- `PROG_DEPTH`, default 15: instruction slots per core.
- `INSTR_W`, default 16: instruction width.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  host byte valid.
- `in_ready`  out  1  loader can accept a byte.
- `in_data`  in  8  host byte.
- `prog`  out  NCORES×PROG_DEPTH×INSTR_W  flattened stores; core c, slot s at bit offset (c·PROG_DEPTH+s)·INSTR_W.
- `pLength`  out  NCORES×4  per-core program length.
- `run`  out  NCORES  core c may execute; when low, core c is held in reset.
- `done`  out  1  one-cycle pulse on commit.
- `err`  out  1  one-cycle pulse on a rejected frame.

## Operation
- Frame format: SYNC (0x5A), CORE (index), LEN (0..PROG_DEPTH), then LEN instructions as HI byte followed by LO byte, then CSUM.
- FSM states: IDLE, CORE, LEN, HI, LO, CSUM, COMMIT.
- IDLE: on a non-SYNC byte, stay in IDLE and discard it. On SYNC, go to CORE and clear the running XOR.
- CORE: if index ≥ NCORES, pulse `err` and go to IDLE. Otherwise latch the index, clear `run[idx]`, and go to LEN.
- LEN: if value > PROG_DEPTH, pulse `err` and go to IDLE; `run[idx]` stays low. Otherwise latch it. If LEN = 0, go to CSUM; else go to HI.
- HI and LO build the instruction word {HI,LO} in shadow slot k, with k counting from 0.
- After LO: if k = LEN−1, go to CSUM; else increment k and go to HI.
- CSUM: the running XOR covers every byte after SYNC, up to and including the last LO. If CSUM equals that XOR, go to COMMIT. Otherwise pulse `err`, go to IDLE, and leave the live store untouched.
- COMMIT (one cycle):
  - Copy the shadow store to the live `prog` for the core.
  - Zero slots ≥ LEN.
  - Set `pLength[idx]` = LEN, set `run[idx]`, and pulse `done`.
  - Return to IDLE.
- Other cores' `prog`, `pLength` and `run` are never disturbed by a frame addressed elsewhere.
- `in_ready` = 1 in every state except COMMIT.

## Timing
- A byte transfers on a rising `clk` edge with `in_valid && in_ready`.
- Commit latency: `prog`, `pLength`, `run` and `done` update one cycle after the CSUM byte is accepted.
- `err` is asserted in the cycle after the offending byte is accepted.
- Reset values: all `prog` zero, all `pLength` zero, `run` all 0, `done` 0, `err` 0, `in_ready` 1, FSM in IDLE.
- `rst` asserted mid-frame aborts the frame. All live stores are also cleared, because reset is global.
- A SYNC value arriving inside a frame is treated as data; there is no resynchronisation until the frame ends or errors.
- Back-to-back frames are allowed. A SYNC offered during COMMIT is stalled one cycle by `in_ready` = 0.

## Configuration
- `PROG_LOADER_CHECKSUM_EN`
  - Defined: CSUM state and XOR check exist as described.
  - Undefined: no CSUM byte is expected. After the final LO, or directly from LEN when LEN = 0, go to COMMIT. `err` is raised only for bad index or length.

## Structure
- Package `prog_loader_pkg` holds:
  - the state enum;
  - `SYNC_BYTE` = 8'h5A;
  - default `PROG_DEPTH` and `INSTR_W`;
  - a `pc_len_t` (4-bit) typedef shared with `core`.
- Sub-module `prog_bank` is one per core. It holds the live store, `pLength` and `run`, with ports for commit-load and run-clear. The FSM and shadow store live in `prog_loader`.

## Test plan
- Reset, then frame 5A 00 02 12 34 AB CD with CSUM = 00^02^12^34^AB^CD = 0x42 → `prog` core0 slot0 = 0x1234, slot1 = 0xABCD, slots 2–14 = 0; `pLength[0]` = 2; `run[0]` = 1; one `done` pulse; core1 untouched.
- Same frame with CSUM 0x43 → `err` pulse; core0 store unchanged; `run[0]` = 0.
- CORE = 02 with NCORES = 2 → `err` the cycle after the CORE byte; FSM back in IDLE; next valid frame to core1 loads normally.
- LEN = 0x10 → `err`; LEN = 0 with CSUM = 0x01 ^ 0x00 to core1 → `pLength[1]` = 0, `run[1]` = 1.
- Assert `rst` after the HI byte of a frame → all outputs return to reset values; the following complete frame commits correctly.
- Garbage bytes 00 FF 5B before SYNC are ignored; two back-to-back frames for cores 0 and 1 both commit, with `in_ready` low for exactly one cycle each.
